full_adder_reg: RTL and testbench



---
 rtl/full_adder_reg.sv | 97 +++++++++
 tb/tb_full_adder_reg.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/full_adder_reg.sv
// Single-bit full adder with a registered output stage and an optional LSB-first
// bit-serial word adder, compiled in when FULL_ADDER_SERIAL_EN is defined.
module full_adder_reg #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a,
    input  logic              b,
    input  logic              c_in,
    input  logic              en,
    input  logic              start,
    output logic              sum,
    output logic              carry_out,
    output logic              sum_q,
    output logic              carry_q,
    output logic [WORD_W-1:0] word_q,
    output logic              done
);

    logic c_eff;

    assign sum       = a ^ b ^ c_eff;
    assign carry_out = (a & b) | (a & c_eff) | (b & c_eff);

`ifdef FULL_ADDER_SERIAL_EN

    localparam int IDX_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;

    logic              busy;
    logic [IDX_W-1:0]  bit_idx;
    logic [WORD_W-1:0] shreg;
    logic              last_bit;

    // A start cycle always takes the external carry so a new word can seed its LSB.
    assign c_eff    = (busy && !start) ? carry_q : c_in;
    assign last_bit = busy && !start && (bit_idx == IDX_W'(WORD_W - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    // NOTE: shreg is a small register file but is still reset, so no stale bits of
    // an aborted or reset word can leak into a later word_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= 1'b0;
            carry_q <= 1'b0;
            word_q  <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            done <= 1'b0;
            if (en) begin
                sum_q   <= sum;
                carry_q <= carry_out;
                if (start) begin
                    busy     <= 1'b1;
                    bit_idx  <= IDX_W'(1);
                    shreg[0] <= sum;
                end else if (busy) begin
                    shreg[bit_idx] <= sum;
                    bit_idx        <= bit_idx + IDX_W'(1);
                    if (last_bit) begin
                        word_q <= {sum, shreg[WORD_W-2:0]};
                        done   <= 1'b1;
                        busy   <= 1'b0;
                    end
                end
            end
        end
    end

`else

    logic unused_start;

    assign unused_start = start;
    assign c_eff        = c_in;
    assign word_q       = '0;
    assign done         = 1'b0;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= 1'b0;
            carry_q <= 1'b0;
        end else if (en) begin
            sum_q   <= sum;
            carry_q <= carry_out;
        end
    end

`endif

endmodule

// File: tb/tb_full_adder_reg.sv
// Self-checking bench for full_adder_reg; expected values come from integer
// arithmetic on whole operands, valid for both the serial and the plain build.
`timescale 1ns/1ps
module tb_full_adder_reg;

    localparam int W = 8;
`ifdef FULL_ADDER_SERIAL_EN
    localparam bit SERIAL = 1'b1;
`else
    localparam bit SERIAL = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         a, b, c_in, en, start;
    logic         sum, carry_out, sum_q, carry_q, done;
    logic [W-1:0] word_q;

    int checks = 0;
    int errors = 0;

    full_adder_reg #(.WORD_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c_in(c_in), .en(en),
        .start(start), .sum(sum), .carry_out(carry_out), .sum_q(sum_q),
        .carry_q(carry_q), .word_q(word_q), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Carry entering bit i of the serial sum A+B+cin.
    function automatic int unsigned carry_into(input logic [W-1:0] aw, input logic [W-1:0] bw,
                                               input logic cin, input int i);
        int unsigned mask;
        mask = (32'd1 << i) - 1;
        return ((int'(aw) & mask) + (int'(bw) & mask) + int'(cin)) >> i;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; a = 1'b0; b = 1'b0; c_in = 1'b0; en = 1'b0; start = 1'b0;
        #12;
        checks++;
        if ({sum_q, carry_q, word_q, done} !== '0)
            begin errors++; $display("FAIL reset_state: got %b expected 0", {sum_q, carry_q, word_q, done}); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_comb();
        logic [7:0] exp_sum   = 8'b1001_0110;
        logic [7:0] exp_carry = 8'b1110_1000;
        en = 1'b0;
        for (int code = 0; code < 8; code++) begin
            {a, b, c_in} = 3'(code);
            #100;
            checks++;
            if (sum !== exp_sum[code] || carry_out !== exp_carry[code])
                begin errors++; $display("FAIL comb_%0d: got sum=%b carry=%b expected sum=%b carry=%b",
                                         code, sum, carry_out, exp_sum[code], exp_carry[code]); end
        end
    endtask

    task automatic test_capture();
        a = 1'b1; b = 1'b1; c_in = 1'b0; en = 1'b1; start = 1'b0;
        tick();
        checks++;
        if (sum_q !== 1'b0 || carry_q !== 1'b1)
            begin errors++; $display("FAIL capture: got sum_q=%b carry_q=%b expected 0 1", sum_q, carry_q); end
        en = 1'b0; a = 1'b0; b = 1'b0; c_in = 1'b1;
        tick(); tick();
        checks++;
        if (sum_q !== 1'b0 || carry_q !== 1'b1)
            begin errors++; $display("FAIL hold: got sum_q=%b carry_q=%b expected 0 1", sum_q, carry_q); end
    endtask

    // Drive n bits of a word starting at bit 0 without completing it.
    task automatic drive_bits(input logic [W-1:0] aw, input logic [W-1:0] bw, input logic cin, input int n);
        for (int i = 0; i < n; i++) begin
            start = (i == 0); en = 1'b1; a = aw[i]; b = bw[i];
            c_in = (i == 0) ? cin : 1'($urandom);
            tick();
            checks++;
            if (done !== 1'b0) begin errors++; $display("FAIL partial_done bit %0d: got %b expected 0", i, done); end
        end
        start = 1'b0; en = 1'b0;
    endtask

    // Full serial word with optional random en gaps; checks comb sum, done timing and result.
    task automatic run_word(input logic [W-1:0] aw, input logic [W-1:0] bw, input logic cin, input int gap_pct);
        int unsigned total, exp_c, last_c;
        logic [W-1:0] exp_word;
        total = int'(aw) + int'(bw) + int'(cin);
        last_c = 0;
        for (int i = 0; i < W; i++) begin
            if (i > 0 && $urandom_range(99) < gap_pct) begin
                en = 1'b0; start = 1'b0; a = 1'($urandom); b = 1'($urandom); c_in = 1'($urandom);
                tick();
                checks++;
                if (done !== 1'b0) begin errors++; $display("FAIL gap_done bit %0d: got %b expected 0", i, done); end
            end
            start = (i == 0); en = 1'b1; a = aw[i]; b = bw[i];
            c_in = (i == 0) ? cin : 1'($urandom);
            #1;
            exp_c = SERIAL ? (carry_into(aw, bw, cin, i) & 1) : int'(c_in);
            last_c = int'(c_in);
            checks++;
            if (sum !== 1'((int'(aw[i]) + int'(bw[i]) + exp_c) & 1))
                begin errors++; $display("FAIL word_sum %h+%h bit %0d: got %b", aw, bw, i, sum); end
            tick();
            checks++;
            if (done !== (SERIAL && i == W - 1))
                begin errors++; $display("FAIL done_timing %h+%h bit %0d: got %b expected %b",
                                         aw, bw, i, done, SERIAL && i == W - 1); end
        end
        exp_word = SERIAL ? W'(total) : '0;
        checks++;
        if (word_q !== exp_word)
            begin errors++; $display("FAIL word_q %h+%h+%0d: got %h expected %h", aw, bw, cin, word_q, exp_word); end
        exp_c = SERIAL ? ((total >> W) & 1) : ((int'(aw[W-1]) + int'(bw[W-1]) + last_c) >> 1);
        checks++;
        if (carry_q !== 1'(exp_c))
            begin errors++; $display("FAIL word_carry %h+%h+%0d: got %b expected %0d", aw, bw, cin, carry_q, exp_c); end
        en = 1'b0; start = 1'b0;
        tick();
        checks++;
        if (done !== 1'b0 || word_q !== exp_word)
            begin errors++; $display("FAIL done_pulse_len: got done=%b word_q=%h expected 0 %h", done, word_q, exp_word); end
    endtask

    task automatic test_serial_add();
        run_word(8'hA5, 8'h3C, 1'b0, 0);
    endtask

    task automatic test_overflow();
        run_word(8'hFF, 8'h01, 1'b0, 0);
        run_word(8'hFF, 8'h01, 1'b0, 60);
    endtask

    task automatic test_reset_mid_word();
        logic exp_s, exp_c;
        run_word(8'h5A, 8'h33, 1'b1, 0);
        drive_bits(8'hC3, 8'h7E, 1'b0, 4);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sum_q, carry_q, word_q, done} !== '0)
            begin errors++; $display("FAIL reset_mid_word: got %b expected 0", {sum_q, carry_q, word_q, done}); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < W + 2; i++) begin
            en = 1'b1; start = 1'b0; a = 1'($urandom); b = 1'($urandom); c_in = 1'($urandom);
            {exp_c, exp_s} = 2'(int'(a) + int'(b) + int'(c_in));
            tick();
            checks++;
            if (done !== 1'b0 || word_q !== '0 || sum_q !== exp_s || carry_q !== exp_c)
                begin errors++; $display("FAIL after_reset cycle %0d: got done=%b word_q=%h sum_q=%b carry_q=%b expected 0 00 %b %b",
                                         i, done, word_q, sum_q, carry_q, exp_s, exp_c); end
        end
        en = 1'b0;
    endtask

    task automatic test_restart();
        drive_bits(8'h81, 8'h92, 1'b1, 4);
        run_word(8'h6D, 8'hB7, 1'b1, 0);
        drive_bits(8'hFF, 8'hFF, 1'b1, 6);
        run_word(8'h10, 8'h20, 1'b0, 40);
    endtask

    task automatic test_random_words();
        for (int n = 0; n < 8; n++)
            run_word(W'($urandom), W'($urandom), 1'($urandom), 30);
    endtask

    task automatic test_random_parallel();
        logic exp_s, exp_c, ena;
        for (int n = 0; n < 24; n++) begin
            ena = 1'($urandom);
            if (ena) begin
                start = 1'b0; en = 1'b1; a = 1'($urandom); b = 1'($urandom); c_in = 1'($urandom);
                {exp_c, exp_s} = 2'(int'(a) + int'(b) + int'(c_in));
            end else begin
                en = 1'b0; a = 1'($urandom); b = 1'($urandom); c_in = 1'($urandom);
                exp_s = sum_q; exp_c = carry_q;
            end
            tick();
            checks++;
            if (sum_q !== exp_s || carry_q !== exp_c)
                begin errors++; $display("FAIL parallel_%0d en=%b: got %b%b expected %b%b",
                                         n, ena, carry_q, sum_q, exp_c, exp_s); end
        end
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_comb();
        test_capture();
        test_serial_add();
        test_overflow();
        test_reset_mid_word();
        test_restart();
        test_random_words();
        test_random_parallel();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
